// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg : channel constants, event-id type and round-robin pick helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package btn_pkg;

   localparam int CH_EAST  = 0;
   localparam int CH_NORTH = 1;
   localparam int CH_WEST  = 2;
   localparam int N_CH     = 3;
   localparam int MILI     = 50000;

   typedef logic [1:0] evt_id_t;

   typedef struct packed {
      logic    found;
      evt_id_t id;
   } grant_t;

   // First requesting channel at or after start, wrapping modulo N_CH.
   function automatic grant_t rr_pick(input logic [N_CH-1:0] req, input evt_id_t start);
      grant_t g;
      int     idx;
      g.found = 1'b0;
      g.id    = start;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(start) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!g.found && req[idx]) begin
            g.found = 1'b1;
            g.id    = evt_id_t'(idx);
         end
      end
      return g;
   endfunction

   function automatic evt_id_t next_ch(input evt_id_t ch);
      return (int'(ch) >= N_CH - 1) ? evt_id_t'(0) : ch + evt_id_t'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// btn_event_arbiter_if : event stream handshake plus status flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface btn_event_arbiter_if;
   import btn_pkg::*;

   logic    evt_valid;
   logic    evt_ready;
   evt_id_t evt_id;
   logic    busy;
   logic    lost;

   modport master (
      output evt_valid,
      output evt_id,
      output busy,
      output lost,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      input  busy,
      input  lost,
      output evt_ready
   );

endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : HOLD-sample qualifier emitting one strobe per press;
// optional auto-repeat every REPEAT cycles when BTN_REPEAT_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
   parameter int HOLD   = 4,
   parameter int REPEAT = 6
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic raw,
   output logic      strobe
);

   localparam int              CW     = $clog2(HOLD + 1);
   localparam logic [CW-1:0]   C_HOLD = CW'(HOLD);
   localparam logic [CW-1:0]   C_ARM  = CW'(HOLD - 1);

   if (HOLD < 1 || REPEAT < 2) begin : g_bad_param
      $error("btn_debounce: HOLD must be >= 1 and REPEAT >= 2");
   end

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (!raw)
         cnt <= '0;
      else if (cnt != C_HOLD)
         cnt <= cnt + 1'b1;
   end

`ifdef BTN_REPEAT_EN
   localparam int            RW      = $clog2(REPEAT);
   localparam logic [RW-1:0] C_RLAST = RW'(REPEAT - 1);

   logic [RW-1:0] rcnt;

   // Runs only while saturated, so its phase is anchored to the initial strobe.
   always_ff @(posedge clk) begin
      if (rst || !raw || cnt != C_HOLD)
         rcnt <= '0;
      else if (rcnt == C_RLAST)
         rcnt <= '0;
      else
         rcnt <= rcnt + 1'b1;
   end

   assign strobe = raw && ((cnt == C_ARM) || ((cnt == C_HOLD) && (rcnt == C_RLAST)));
`else
   assign strobe = raw && (cnt == C_ARM);
`endif

endmodule

`default_nettype wire

// File: rtl/btn_event_arbiter.sv
// ---------------------------------------------------------------------------
// btn_event_arbiter : debounced buttons -> pending bits -> round-robin event
// stream. Optional auto-repeat: define BTN_REPEAT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_event_arbiter
   import btn_pkg::*;
#(
   parameter int HOLD   = 100 * MILI,
   parameter int REPEAT = 500 * MILI
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic [N_CH-1:0] btn_in,
   btn_event_arbiter_if.master  evt
);

   logic [N_CH-1:0] strobe;
   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] clr;
   evt_id_t         rr;
   evt_id_t         id_q;
   logic            valid_q;
   logic            lost_q;
   grant_t          gnt;
   logic            load;
   logic            take;
   logic            lost_hit;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_debounce #(
         .HOLD   (HOLD),
         .REPEAT (REPEAT)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .raw    (btn_in[i]),
         .strobe (strobe[i])
      );
   end

   always_comb begin
      gnt  = rr_pick(pending, rr);
      load = !valid_q || evt.evt_ready;
      take = load && gnt.found;
      clr  = '0;
      for (int i = 0; i < N_CH; i++) begin
         clr[i] = take && (gnt.id == evt_id_t'(i));
      end
      // A strobe on the channel being granted this cycle is not a drop.
      lost_hit = |(strobe & pending & ~clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         rr      <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         pending <= (pending & ~clr) | strobe;
         if (lost_hit)
            lost_q <= 1'b1;
         if (take) begin
            id_q    <= gnt.id;
            valid_q <= 1'b1;
            rr      <= next_ch(gnt.id);
         end else if (load) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_id    = id_q;
   assign evt.lost      = lost_q;
   assign evt.busy      = (|pending) || valid_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_btn_event_arbiter : directed stimulus with a queue-based event scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_btn_event_arbiter;
   import btn_pkg::*;

   localparam int HOLD   = 4;
   localparam int REPEAT = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  btn = 3'b000;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic [1:0] id;
      int         cyc;
   } exp_t;

   exp_t sb[$];

   btn_event_arbiter_if evt ();

   btn_event_arbiter #(
      .HOLD   (HOLD),
      .REPEAT (REPEAT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn),
      .evt    (evt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int id, input int c);
      exp_t e;
      e.id  = 2'(id);
      e.cyc = c;
      sb.push_back(e);
   endtask

   // Monitor: every accepted event is matched against the head of the queue.
   always @(negedge clk) begin
      if (!rst && evt.evt_valid && evt.evt_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got id %0d, required no event (cycle %0d)", evt.evt_id, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("evt_id", int'(evt.evt_id), int'(e.id));
            if (e.cyc >= 0) chk("evt_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      int c0;
      int bounce[10] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0};
      evt.evt_ready = 1'b0;

      // Reset state
      tick(2);
      chk("reset_valid", int'(evt.evt_valid), 0);
      chk("reset_id",    int'(evt.evt_id),    0);
      chk("reset_busy",  int'(evt.busy),      0);
      chk("reset_lost",  int'(evt.lost),      0);
      rst = 1'b0;

      // Single east press, consumer always ready
      evt.evt_ready = 1'b1;
      btn = 3'b001;
      c0  = cyc;
      push(CH_EAST, c0 + 5);
`ifdef BTN_REPEAT_EN
      push(CH_EAST, c0 + 11);
`endif
      tick(4);
      chk("east_pending_valid", int'(evt.evt_valid), 0);
      chk("east_pending_busy",  int'(evt.busy),      1);
      tick(1);
      chk("east_valid", int'(evt.evt_valid), 1);
      chk("east_id",    int'(evt.evt_id),    CH_EAST);
      tick(5);
      btn = 3'b000;
      tick(6);
      chk("east_busy_done", int'(evt.busy), 0);
      chk("east_lost",      int'(evt.lost), 0);
      chk("east_drained",   sb.size(),      0);

      // Bounce never reaches HOLD consecutive highs
      for (int i = 0; i < 10; i++) begin
         btn = 3'(bounce[i]);
         tick(1);
         chk("bounce_busy", int'(evt.busy), 0);
      end

      // Reset with buttons high wipes partial qualification
      evt.evt_ready = 1'b0;
      btn = 3'b111;
      tick(2);
      rst = 1'b1;
      tick(1);
      chk("rst_hi_valid", int'(evt.evt_valid), 0);
      chk("rst_hi_busy",  int'(evt.busy),      0);
      rst = 1'b0;
      btn = 3'b101;
      tick(3);
      chk("requal_3_busy", int'(evt.busy), 0);
      tick(1);
      chk("requal_4_busy", int'(evt.busy), 1);
      btn = 3'b000;
      tick(1);
      chk("pair_valid", int'(evt.evt_valid), 1);
      chk("pair_id",    int'(evt.evt_id),    CH_EAST);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("hold_valid", int'(evt.evt_valid), 1);
         chk("hold_id",    int'(evt.evt_id),    CH_EAST);
      end
      push(CH_EAST, -1);
      push(CH_WEST, -1);
      evt.evt_ready = 1'b1;
      tick(1);
      evt.evt_ready = 1'b0;
      chk("pair_second_valid", int'(evt.evt_valid), 1);
      chk("pair_second_id",    int'(evt.evt_id),    CH_WEST);
      tick(2);
      chk("pair_second_held", int'(evt.evt_id), CH_WEST);
      evt.evt_ready = 1'b1;
      tick(1);
      evt.evt_ready = 1'b0;
      chk("pair_done_valid", int'(evt.evt_valid), 0);
      chk("pair_done_busy",  int'(evt.busy),      0);

      // Same pair again: pointer sits at east after west was served
      btn = 3'b101;
      tick(4);
      btn = 3'b000;
      tick(1);
      chk("rr_again_valid", int'(evt.evt_valid), 1);
      chk("rr_again_id",    int'(evt.evt_id),    CH_EAST);
      push(CH_EAST, -1);
      push(CH_WEST, -1);
      evt.evt_ready = 1'b1;
      tick(3);
      evt.evt_ready = 1'b0;
      chk("rr_again_busy", int'(evt.busy), 0);

      // North occupies the output; east pending; second east press is dropped
      btn = 3'b010;
      tick(4);
      btn = 3'b000;
      tick(1);
      btn = 3'b001;
      tick(4);
      btn = 3'b000;
      tick(1);
      chk("lost_before", int'(evt.lost), 0);
      chk("lost_busy",   int'(evt.busy), 1);
      btn = 3'b001;
      tick(4);
      btn = 3'b000;
      tick(1);
      chk("lost_after", int'(evt.lost), 1);
      push(CH_NORTH, -1);
      push(CH_EAST,  -1);
      evt.evt_ready = 1'b1;
      tick(4);
      evt.evt_ready = 1'b0;
      chk("lost_drain_busy", int'(evt.busy), 0);
      chk("lost_sticky",     int'(evt.lost), 1);
      chk("lost_drained",    sb.size(),      0);

      // Reset while an event is held and north is pending
      btn = 3'b001;
      tick(4);
      btn = 3'b000;
      tick(1);
      btn = 3'b010;
      tick(4);
      btn = 3'b000;
      tick(1);
      chk("mid_valid", int'(evt.evt_valid), 1);
      chk("mid_busy",  int'(evt.busy),      1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid_rst_valid", int'(evt.evt_valid), 0);
      chk("mid_rst_busy",  int'(evt.busy),      0);
      chk("mid_rst_lost",  int'(evt.lost),      0);
      chk("mid_rst_id",    int'(evt.evt_id),    0);
      evt.evt_ready = 1'b1;
      tick(10);
      chk("post_rst_valid", int'(evt.evt_valid), 0);
      chk("post_rst_busy",  int'(evt.busy),      0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
